pwm_capture: RTL

- Receive-side counterpart to the team's PWM generator. Measures an incoming PWM waveform and reports period, high time and a 4-bit quantised duty cycle.
- The duty_cycle output uses the same 0–15 encoding that drives the duty display and the LED path, so it feeds those blocks directly.
- Used for loopback checking of the generator and for reading external PWM sources.

---
 rtl/pwm_capture_pkg.sv | 16 +
 rtl/pwm_duty_div.sv | 69 ++++++
 rtl/pwm_capture.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM capture block: FSM state encoding and
// the default counter/duty/synchroniser widths.
package pwm_capture_pkg;

    localparam int CNT_W_DEF       = 20;
    localparam int DUTY_W_DEF      = 4;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_TRACK = 2'd2,
        ST_DIV   = 2'd3
    } cap_state_e;

endpackage : pwm_capture_pkg

// File: rtl/pwm_duty_div.sv
// Sequential restoring divider producing q = floor(num * 2^Q_FRAC / den)
// as a Q_FRAC+1 bit quotient. Valid while num < 2*den, which holds for
// high-time / period operands. Latency from start to done is Q_FRAC+1 clocks.
module pwm_duty_div
    import pwm_capture_pkg::*;
#(
    parameter int NUM_W  = CNT_W_DEF,
    parameter int Q_FRAC = DUTY_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [NUM_W-1:0]  num,
    input  logic [NUM_W-1:0]  den,
    output logic [Q_FRAC:0]   q,
    output logic              done
);

    localparam int STEP_W = $clog2(Q_FRAC + 2);
    localparam logic [STEP_W-1:0] STEPS    = STEP_W'(Q_FRAC + 1);
    localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

    logic [NUM_W:0]   rem_r;
    logic [NUM_W-1:0] den_r;
    logic [STEP_W-1:0] step_r;
    logic             busy_r;

    logic [NUM_W+1:0] diff_s;
    logic             ge_s;
    logic [NUM_W:0]   rem_next_s;

    // Trial subtraction: the sign bit of the widened difference tells whether
    // the divisor fits into the current partial remainder.
    assign diff_s     = {1'b0, rem_r} - {2'b00, den_r};
    assign ge_s       = ~diff_s[NUM_W+1];
    assign rem_next_s = ge_s ? diff_s[NUM_W:0] : rem_r;

    // One quotient bit per clock, MSB first, remainder shifted left each step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_r  <= {(NUM_W+1){1'b0}};
            den_r  <= {NUM_W{1'b0}};
            q      <= {(Q_FRAC+1){1'b0}};
            step_r <= {STEP_W{1'b0}};
            busy_r <= 1'b0;
            done   <= 1'b0;
        end else if (start) begin
            rem_r  <= {1'b0, num};
            den_r  <= den;
            q      <= {(Q_FRAC+1){1'b0}};
            step_r <= STEPS;
            busy_r <= 1'b1;
            done   <= 1'b0;
        end else if (busy_r) begin
            rem_r  <= rem_next_s << 1'b1;
            q      <= {q[Q_FRAC-1:0], ge_s};
            step_r <= step_r - STEP_ONE;
            if (step_r == STEP_ONE) begin
                busy_r <= 1'b0;
                done   <= 1'b1;
            end else begin
                done   <= 1'b0;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule : pwm_duty_div

// File: rtl/pwm_capture.sv
// PWM capture: synchronises an asynchronous PWM input, measures period and
// high time in clocks, and reports a quantised duty cycle with a one-cycle
// valid pulse. Detects a stuck input and reports it as a timeout.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DUTY_W      = DUTY_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF   // must be at least 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty_cycle,
    output logic [CNT_W-1:0]  period,
    output logic [CNT_W-1:0]  high_time,
    output logic              valid,
    output logic              locked,
    output logic              timeout
);

    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [DUTY_W-1:0] DUTY_MAX = {DUTY_W{1'b1}};

    // Clamp the DUTY_W+1 bit quotient into the DUTY_W bit display code.
    function automatic logic [DUTY_W-1:0] sat_duty(input logic [DUTY_W:0] q_in);
        logic [DUTY_W-1:0] res;
        if (q_in[DUTY_W]) begin
            res = DUTY_MAX;
        end else begin
            res = q_in[DUTY_W-1:0];
        end
        return res;
    endfunction

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   lvl_d_r;
    logic                   lvl_s;
    logic                   rise_s;
    logic                   fall_s;

    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       hi_lat_r;
    logic [CNT_W-1:0]       op_per_r;
    logic [CNT_W-1:0]       op_hi_r;

    cap_state_e             state_r;
    logic                   div_start_s;
    logic [DUTY_W:0]        div_q_s;
    logic                   div_done_s;

    assign lvl_s  = sync_r[SYNC_STAGES-1];
    assign rise_s = lvl_s & ~lvl_d_r;
    assign fall_s = ~lvl_s & lvl_d_r;

    // A rise only starts a division when a measurement is being accepted;
    // a rise arriving while the divider is busy is dropped.
    assign div_start_s = rise_s & ((state_r == ST_ARM) | (state_r == ST_TRACK));

    // Input synchroniser chain plus one delay flop for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_r  <= {SYNC_STAGES{1'b0}};
            lvl_d_r <= 1'b0;
        end else begin
            sync_r  <= {sync_r[SYNC_STAGES-2:0], pwm_in};
            lvl_d_r <= lvl_s;
        end
    end

    // Free-running edge-to-edge counter with high-time latch on the falling edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r    <= CNT_ZERO;
            hi_lat_r <= CNT_ZERO;
        end else begin
            if (rise_s) begin
                cnt_r <= CNT_ONE;
            end else if (cnt_r != CNT_MAX) begin
                cnt_r <= cnt_r + CNT_ONE;
            end
            if (fall_s) begin
                hi_lat_r <= cnt_r;
            end
        end
    end

    // Duty division; operands are the period ending at this rise and the
    // high time latched at the preceding fall.
    pwm_duty_div #(
        .NUM_W  (CNT_W),
        .Q_FRAC (DUTY_W)
    ) u_div (
        .clk   (clk),
        .reset (reset),
        .start (div_start_s),
        .num   (hi_lat_r),
        .den   (cnt_r),
        .q     (div_q_s),
        .done  (div_done_s)
    );

    // Measurement FSM with registered result, status and valid outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            op_per_r   <= CNT_ZERO;
            op_hi_r    <= CNT_ZERO;
            duty_cycle <= {DUTY_W{1'b0}};
            period     <= CNT_ZERO;
            high_time  <= CNT_ZERO;
            valid      <= 1'b0;
            locked     <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // The partial period before the first rise is discarded.
                    if (rise_s) begin
                        state_r <= ST_ARM;
                    end
                end
                ST_ARM, ST_TRACK: begin
                    if (rise_s) begin
                        op_per_r <= cnt_r;
                        op_hi_r  <= hi_lat_r;
                        state_r  <= ST_DIV;
                    end else if (cnt_r == CNT_MAX) begin
                        // Stuck input: report the level it is stuck at.
                        duty_cycle <= lvl_s ? DUTY_MAX : {DUTY_W{1'b0}};
                        period     <= CNT_ZERO;
                        high_time  <= CNT_ZERO;
                        valid      <= 1'b1;
                        locked     <= 1'b0;
                        timeout    <= 1'b1;
                        state_r    <= ST_IDLE;
                    end
                end
                ST_DIV: begin
                    if (div_done_s) begin
                        duty_cycle <= sat_duty(div_q_s);
                        period     <= op_per_r;
                        high_time  <= op_hi_r;
                        valid      <= 1'b1;
                        locked     <= 1'b1;
                        timeout    <= 1'b0;
                        state_r    <= ST_TRACK;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : pwm_capture
